// File: rtl/bitvault_pkg.sv
// rtl/bitvault_pkg.sv - shared types and helpers for the bitvault register file
package bitvault_pkg;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    function automatic int calc_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/bitvault_clr_fsm.sv
// rtl/bitvault_clr_fsm.sv - sequential clear engine sweeping one entry per cycle
module bitvault_clr_fsm
    import bitvault_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLR_SWEEP: begin
                // Exit on the last entry so the index never has to wrap.
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = CLR_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = CLR_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign clr_en  = (state_q == CLR_SWEEP);
    assign clr_idx = idx_q;

endmodule

// File: rtl/bitvault_mpregfile.sv
// rtl/bitvault_mpregfile.sv - 1W2R register file with per-entry write locks and clear sweep
module bitvault_mpregfile
    import bitvault_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             lock,
    input  logic             clr_req,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic [DEPTH-1:0] locked,
    output logic             busy,
    output logic             wr_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] locked_q, locked_d;
    logic             wr_err_q, wr_err_d;
    logic             clr_en;
    logic [AW-1:0]    clr_idx;
    logic             wr_in_range;
    logic             wr_hit_lock;
    logic             wr_ok;

    bitvault_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    always_comb begin
        wr_in_range = (int'(waddr) < DEPTH);
        wr_hit_lock = 1'b0;
        if (wr_in_range) begin
            wr_hit_lock = locked_q[waddr];
        end
        // A pending clear request outranks any write in the same cycle.
        wr_ok    = we && !busy && !clr_req && wr_in_range && !wr_hit_lock;
        wr_err_d = we && !wr_ok;

        mem_d    = mem_q;
        locked_d = locked_q;
        if (wr_ok) begin
            mem_d[waddr] = wdata;
            if (lock) begin
                locked_d[waddr] = 1'b1;
            end
        end
        if (clr_en) begin
            mem_d[clr_idx]    = '0;
            locked_d[clr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            locked_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            locked_q <= locked_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rdata_a = (int'(raddr_a) < DEPTH) ? mem_q[raddr_a] : '0;
    assign rdata_b = (int'(raddr_b) < DEPTH) ? mem_q[raddr_b] : '0;
    assign locked  = locked_q;
    assign wr_err  = wr_err_q;

endmodule
